tick_counter_bank: RTL and testbench
====================================

// Module: tick_counter_bank
// PURPOSE
//  Multi-channel, parametrised successor to the single free-running LED counter.
//  One shared clock-enable prescaler drives CH independent W-bit counters.
//  Each counter has its own direction, its own mode (wrap/saturate/one-shot/reload),
//  a synchronous load and a terminal-count pulse.
//  Sits beside the top-level glue; drives LEDs/hex displays and timing strobes for future UUVs.
// PARAMETERS
//  CH   4          number of counter channels (>=1)
//  W    10         counter width in bits (>=1)
//  DIV  5_000_000  prescaler ratio: one tick every DIV enabled clk cycles (>=1; 1 = every cycle)
// PORTS
//  clk       in   1        system clock, all logic rising-edge
//  rst       in   1        asynchronous reset, active-high
//  ena       in   1        global enable; low freezes prescaler (so no ticks)
//  ch_ena    in   CH       per-channel count enable
//  dir       in   CH       per-channel direction: 0 = up, 1 = down
//  mode      in   CH x 2   00 wrap, 01 saturate, 10 one-shot, 11 reload
//  load      in   CH       per-channel synchronous load strobe
//  load_val  in   CH x W   value written on load / used by reload mode
//  limit     in   CH x W   top value: up-terminal and down-wrap target
//  count     out  CH x W   current counter values (registered)
//  tc        out  CH       terminal-count pulse, 1 clk wide (registered)
//  done      out  CH       one-shot finished flag (registered)
//  tick      out  1        prescaler strobe, for daisy-chaining
// BEHAVIOUR
//  Reset (async, rst=1): prescaler=0, count=0, tc=0, done=0 on all channels; tick=0 while rst high.
//  Prescaler:
//   - pre counts 0..DIV-1 on cycles with ena=1; holds when ena=0.
//   - tick = ena && (pre==DIV-1), combinational from pre; pre returns to 0 on that cycle.
//   - DIV=1: tick = ena.
//  Channel i, evaluated at each clk edge, in priority order:
//   1. load[i]=1: count<=load_val[i], done<=0, tc<=0. Load wins over a simultaneous step.
//   2. step = tick && ch_ena[i] && !done[i]. With step=0: count holds, tc<=0.
//   3. Terminal condition: up is count>=limit[i]; down is count==0.
//      If not terminal: count+1 (up) or count-1 (down), tc<=0.
//      If terminal: tc<=1, and by mode:
//       - wrap:      up -> 0; down -> limit[i]
//       - saturate:  count holds; tc re-pulses on every further step at terminal
//       - one-shot:  count holds, done<=1; done blocks further steps until load
//       - reload:    count<=load_val[i] (either direction)
//  Latency: count/tc update on the clk edge at which tick is high; visible the next cycle.
//  Width/limit rules:
//   - Arithmetic is mod 2^W, but the up-terminal compare is >=. A count loaded above limit
//     is therefore terminal on its next up-step; it never runs to 2^W-1.
//   - limit=0 with up: every step is terminal.
//   - limit changes take effect on the next step.
//  Mode and dir changes take effect on the next step. done is cleared only by load or rst.
//  Channels are fully independent; all may step and pulse tc on the same cycle.
//  rst mid-count: immediate async clear; the prescaler phase restarts at 0.
// TESTING
//  T1 DIV=4, ena=1, ch0 up/wrap, limit=3: ticks every 4th clk; count 0,1,2,3,0; tc pulses once on the 3->0 step.
//  T2 ch1 down/saturate from load_val=2: count 2,1,0,0,0; tc pulses on each step taken at 0; count never goes to limit.
//  T3 ch2 up/one-shot, limit=5: reaches 5, done=1, tc once; further ticks leave count=5.
//     load with load_val=1: done=0 next cycle, count=1, counting resumes.
//  T4 ch3 up/reload, load_val=7, limit=9: sequence 7,8,9,7.
//     load and step on the same edge: count=load_val, tc=0.
//  T5 ena=0 for 10 cycles mid-period: no tick, pre and all counts frozen; phase resumes unchanged.
//  T6 rst pulse asserted between clk edges mid-count: all count/tc/done clear immediately.
//     Next tick occurs DIV cycles after rst deasserts.

Source files
------------

// File: rtl/tick_counter_bank.sv
// Bank of CH independent W-bit tick counters sharing one prescaler.
// Each channel supports up/down, wrap/saturate/one-shot/reload and sync load.
module tick_counter_bank #(
  parameter int CH  = 4,
  parameter int W   = 10,
  parameter int DIV = 5_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ena,
  input  logic [CH-1:0]         i_ch_ena,
  input  logic [CH-1:0]         i_dir,
  input  logic [CH-1:0][1:0]    i_mode,
  input  logic [CH-1:0]         i_load,
  input  logic [CH-1:0][W-1:0]  i_load_val,
  input  logic [CH-1:0][W-1:0]  i_limit,
  output logic [CH-1:0][W-1:0]  o_count,
  output logic [CH-1:0]         o_tc,
  output logic [CH-1:0]         o_done,
  output logic                  o_tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  localparam logic [1:0] M_WRAP = 2'b00;
  localparam logic [1:0] M_SAT  = 2'b01;
  localparam logic [1:0] M_ONE  = 2'b10;
  localparam logic [1:0] M_RLD  = 2'b11;

  logic [PW-1:0] r_pre;
  logic          w_tick;

  // Tick is forced low during reset so DIV=1 cannot strobe under rst.
  assign w_tick = i_ena && !i_rst && (r_pre == PMAX);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre <= '0;
    end else if (i_ena) begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end
  end

  logic [CH-1:0][W-1:0] r_count;
  logic [CH-1:0]        r_tc;
  logic [CH-1:0]        r_done;

  assign o_count = r_count;
  assign o_tc    = r_tc;
  assign o_done  = r_done;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic         w_step;
    logic         w_term;
    logic [W-1:0] w_nxt_count;
    logic         w_nxt_tc;
    logic         w_nxt_done;

    assign w_step = w_tick && i_ch_ena[g] && !r_done[g];
    // Up-terminal is >= so a count loaded above limit never runs away.
    assign w_term = i_dir[g] ? (r_count[g] == '0)
                             : (r_count[g] >= i_limit[g]);

    always_comb begin
      w_nxt_count = r_count[g];
      w_nxt_tc    = 1'b0;
      w_nxt_done  = r_done[g];
      if (i_load[g]) begin
        w_nxt_count = i_load_val[g];
        w_nxt_done  = 1'b0;
      end else if (w_step) begin
        if (!w_term) begin
          w_nxt_count = i_dir[g] ? r_count[g] - W'(1)
                                 : r_count[g] + W'(1);
        end else begin
          w_nxt_tc = 1'b1;
          case (i_mode[g])
            M_WRAP:  w_nxt_count = i_dir[g] ? i_limit[g] : '0;
            M_SAT:   w_nxt_count = r_count[g];
            M_ONE:   w_nxt_done  = 1'b1;
            M_RLD:   w_nxt_count = i_load_val[g];
            default: w_nxt_count = r_count[g];
          endcase
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_count[g] <= '0;
        r_tc[g]    <= 1'b0;
        r_done[g]  <= 1'b0;
      end else begin
        r_count[g] <= w_nxt_count;
        r_tc[g]    <= w_nxt_tc;
        r_done[g]  <= w_nxt_done;
      end
    end
  end

endmodule

// File: tb/tb_tick_counter_bank.sv
// Directed bench for tick_counter_bank with DIV=4, CH=4, W=10.
// Each scenario task drives stimulus and checks hand-computed values.
module tb_tick_counter_bank;

  localparam int CH  = 4;
  localparam int W   = 10;
  localparam int DIV = 4;

  logic                 clk;
  logic                 rst;
  logic                 ena;
  logic [CH-1:0]        ch_ena;
  logic [CH-1:0]        dir;
  logic [CH-1:0][1:0]   mode;
  logic [CH-1:0]        load;
  logic [CH-1:0][W-1:0] load_val;
  logic [CH-1:0][W-1:0] limit;
  logic [CH-1:0][W-1:0] count;
  logic [CH-1:0]        tc;
  logic [CH-1:0]        done;
  logic                 tick;

  int checks;
  int failures;

  tick_counter_bank #(.CH(CH), .W(W), .DIV(DIV)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ena      (ena),
    .i_ch_ena   (ch_ena),
    .i_dir      (dir),
    .i_mode     (mode),
    .i_load     (load),
    .i_load_val (load_val),
    .i_limit    (limit),
    .o_count    (count),
    .o_tc       (tc),
    .o_done     (done),
    .o_tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_tick_high();
    int n;
    n = 0;
    while (!tick && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("FAIL tick_timeout got=%b exp=1", tick);
    end
  endtask

  task automatic step_tick();
    wait_tick_high();
    @(posedge clk); #1;
  endtask

  task automatic load_ch(input int c, input logic [W-1:0] v);
    load_val[c] = v;
    load[c] = 1'b1;
    @(posedge clk); #1;
    load[c] = 1'b0;
  endtask

  task automatic test_reset();
    ena = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (count !== '0 || tc !== '0 || done !== '0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got cnt=%h tc=%b done=%b tick=%b exp 0",
               count, tc, done, tick);
    end
    rst = 1'b0;
    checks++;
    if (tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_tick got=%b exp=0", tick);
    end
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] ec [4] = '{10'd1, 10'd2, 10'd3, 10'd0};
    logic         et [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int n;
    ch_ena = '0;
    dir[0] = 1'b0;
    mode[0] = 2'b00;
    limit[0] = 10'd3;
    load_ch(0, 10'd0);
    ch_ena = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step_tick();
      checks++;
      if (count[0] !== ec[i] || tc[0] !== et[i]) begin
        failures++;
        $display("FAIL up_wrap[%0d] got cnt=%0d tc=%b exp cnt=%0d tc=%b",
                 i, count[0], tc[0], ec[i], et[i]);
      end
    end
    n = 0;
    while (!tick && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 3 || tc[0] !== 1'b0 || count[0] !== 10'd0) begin
      failures++;
      $display("FAIL tick_period got gap=%0d tc=%b cnt=%0d exp gap=3 tc=0 cnt=0",
               n, tc[0], count[0]);
    end
  endtask

  task automatic test_down_sat();
    logic [W-1:0] ec [4] = '{10'd1, 10'd0, 10'd0, 10'd0};
    logic         et [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    ch_ena = '0;
    dir[1] = 1'b1;
    mode[1] = 2'b01;
    limit[1] = 10'd5;
    load_ch(1, 10'd2);
    ch_ena = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step_tick();
      checks++;
      if (count[1] !== ec[i] || tc[1] !== et[i] || done[1] !== 1'b0) begin
        failures++;
        $display("FAIL down_sat[%0d] got cnt=%0d tc=%b done=%b exp cnt=%0d tc=%b done=0",
                 i, count[1], tc[1], done[1], ec[i], et[i]);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] ec [4] = '{10'd4, 10'd5, 10'd5, 10'd5};
    logic         et [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic         ed [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    ch_ena = '0;
    dir[2] = 1'b0;
    mode[2] = 2'b10;
    limit[2] = 10'd5;
    load_ch(2, 10'd3);
    ch_ena = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step_tick();
      checks++;
      if (count[2] !== ec[i] || tc[2] !== et[i] || done[2] !== ed[i]) begin
        failures++;
        $display("FAIL one_shot[%0d] got cnt=%0d tc=%b done=%b exp cnt=%0d tc=%b done=%b",
                 i, count[2], tc[2], done[2], ec[i], et[i], ed[i]);
      end
    end
    load_ch(2, 10'd1);
    checks++;
    if (count[2] !== 10'd1 || done[2] !== 1'b0) begin
      failures++;
      $display("FAIL one_shot_load got cnt=%0d done=%b exp cnt=1 done=0",
               count[2], done[2]);
    end
    step_tick();
    checks++;
    if (count[2] !== 10'd2) begin
      failures++;
      $display("FAIL one_shot_resume got cnt=%0d exp=2", count[2]);
    end
  endtask

  task automatic test_reload();
    logic [W-1:0] ec [3] = '{10'd8, 10'd9, 10'd7};
    logic         et [3] = '{1'b0, 1'b0, 1'b1};
    ch_ena = '0;
    dir[3] = 1'b0;
    mode[3] = 2'b11;
    limit[3] = 10'd9;
    load_ch(3, 10'd7);
    ch_ena = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step_tick();
      checks++;
      if (count[3] !== ec[i] || tc[3] !== et[i]) begin
        failures++;
        $display("FAIL reload[%0d] got cnt=%0d tc=%b exp cnt=%0d tc=%b",
                 i, count[3], tc[3], ec[i], et[i]);
      end
    end
    wait_tick_high();
    load_val[3] = 10'd4;
    load[3] = 1'b1;
    @(posedge clk); #1;
    load[3] = 1'b0;
    checks++;
    if (count[3] !== 10'd4 || tc[3] !== 1'b0) begin
      failures++;
      $display("FAIL load_beats_step got cnt=%0d tc=%b exp cnt=4 tc=0",
               count[3], tc[3]);
    end
  endtask

  task automatic test_ena_freeze();
    int bad;
    int n;
    ch_ena = '0;
    dir[0] = 1'b0;
    mode[0] = 2'b00;
    limit[0] = 10'd9;
    load_ch(0, 10'd0);
    ch_ena = 4'b0001;
    step_tick();
    checks++;
    if (count[0] !== 10'd1) begin
      failures++;
      $display("FAIL freeze_pre got cnt=%0d exp=1", count[0]);
    end
    @(posedge clk); #1;
    ena = 1'b0;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tick !== 1'b0 || count[0] !== 10'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL freeze_hold got bad_cycles=%0d exp=0", bad);
    end
    ena = 1'b1;
    n = 0;
    while (!tick && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL freeze_phase got gap=%0d exp=2", n);
    end
    @(posedge clk); #1;
    checks++;
    if (count[0] !== 10'd2) begin
      failures++;
      $display("FAIL freeze_resume got cnt=%0d exp=2", count[0]);
    end
  endtask

  task automatic test_async_reset();
    int n;
    ch_ena = '0;
    dir[2] = 1'b0;
    mode[2] = 2'b10;
    limit[2] = 10'd5;
    load_ch(2, 10'd5);
    ch_ena = 4'b0101;
    step_tick();
    checks++;
    if (done[2] !== 1'b1 || tc[2] !== 1'b1 || count[0] !== 10'd3) begin
      failures++;
      $display("FAIL pre_rst got done=%b tc=%b cnt0=%0d exp done=1 tc=1 cnt0=3",
               done[2], tc[2], count[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== '0 || tc !== '0 || done !== '0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL async_clear got cnt=%h tc=%b done=%b tick=%b exp 0",
               count, tc, done, tick);
    end
    #3;
    rst = 1'b0;
    n = 0;
    while (!tick && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL rst_phase got gap=%0d exp=3", n);
    end
    @(posedge clk); #1;
    checks++;
    if (count[0] !== 10'd1 || count[2] !== 10'd1) begin
      failures++;
      $display("FAIL rst_resume got cnt0=%0d cnt2=%0d exp 1 1",
               count[0], count[2]);
    end
  endtask

  task automatic test_boundary();
    ch_ena = '0;
    dir = 4'b0010;
    mode[0] = 2'b00;
    mode[1] = 2'b00;
    mode[2] = 2'b00;
    limit[0] = 10'd0;
    limit[1] = 10'd6;
    limit[2] = 10'd3;
    load_ch(0, 10'd0);
    load_ch(1, 10'd0);
    load_ch(2, 10'd8);
    ch_ena = 4'b0111;
    step_tick();
    checks++;
    if (count[0] !== 10'd0 || count[1] !== 10'd6 || count[2] !== 10'd0 ||
        tc[2:0] !== 3'b111) begin
      failures++;
      $display("FAIL boundary_1 got c0=%0d c1=%0d c2=%0d tc=%b exp 0 6 0 111",
               count[0], count[1], count[2], tc[2:0]);
    end
    step_tick();
    checks++;
    if (count[0] !== 10'd0 || count[1] !== 10'd5 || count[2] !== 10'd1 ||
        tc[2:0] !== 3'b001) begin
      failures++;
      $display("FAIL boundary_2 got c0=%0d c1=%0d c2=%0d tc=%b exp 0 5 1 001",
               count[0], count[1], count[2], tc[2:0]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ena      = 1'b0;
    ch_ena   = '0;
    dir      = '0;
    mode     = '0;
    load     = '0;
    load_val = '0;
    limit    = '0;
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_one_shot();
    test_reload();
    test_ena_freeze();
    test_async_reset();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
